uart8_echo_responder: RTL and testbench
=======================================

Name: uart8_echo_responder

Overview:
Far-end responder for a Uart8 link. It sits beside one Uart8 instance, takes every byte that instance's receiver delivers, and queues it in a small FIFO. It then drives that instance's transmitter to send each byte back, in order. It is the loopback partner for link-level benches and board bring-up, closing the path initiator tx -> responder rx -> responder tx -> initiator rx.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
DROP_ON_ERR, 1, 1 = bytes flagged by rxErr are discarded; 0 = they are echoed anyway.
START_TIMEOUT, 4095, clk cycles to wait for txBusy after raising txStart before aborting and retrying.

Ports:
clk  input  1  system clock, same clock as the attached Uart8.
rstN  input  1  synchronous active-low reset.
enable  input  1  responder enable.
uartEn  output  1  registered copy of enable; drives Uart8 rxEn and txEn.
rxDone  input  1  Uart8 rxDone; level may persist for many clk cycles.
rxErr  input  1  Uart8 rxErr; qualified by rxDone.
rxByte  input  8  Uart8 out.
txBusy  input  1  Uart8 txBusy.
txDone  input  1  Uart8 txDone; level may persist for many clk cycles.
txStart  output  1  Uart8 txStart.
txByte  output  8  Uart8 in; stable from txStart rise until txDone rise.
fifoCount  output  $clog2(DEPTH)+1  entries currently queued.
overflow  output  1  sticky; set when a byte is dropped because the FIFO is full.
clrOverflow  input  1  synchronous clear of overflow; clear wins over a same-cycle set.
errCount  output  8  count of rxDone events with rxErr; saturates at 255.

Behaviour:
- Reset (rstN low at a clk edge): uartEn=0, txStart=0, txByte=0, fifoCount=0, overflow=0, errCount=0; FSM=IDLE; edge-detect registers cleared.
- Edge detection: rxDone and txDone are each registered every cycle. An event is the cycle where the input is 1 and the registered copy is 0. Only one event occurs per pulse, however long the pulse is.
- rx event, rxErr=1:
  - errCount increments.
  - DROP_ON_ERR=1: no push.
- rx event, otherwise: push rxByte.
- Push while full: byte discarded, overflow=1, count unchanged.
- Pop happens only on the IDLE->START transition.
- Push and pop in the same cycle: both succeed; count unchanged. This holds even when full, because the pop frees the slot first.
- FSM states and transitions:
  - IDLE: txStart=0. Move to START when uartEn=1, fifoCount!=0 and txBusy=0. On that transition, txByte is loaded from the FIFO head and the entry is popped.
  - START: txStart=1. When txBusy=1, move to SEND. If START_TIMEOUT cycles pass with no txBusy, move to IDLE and push the byte back to the FIFO head so it is retried (head retained).
  - SEND: txStart=0. Deasserted on entry so the transmitter never re-arms. On a txDone event, move to IDLE.
- Latency: an rx event in cycle N makes fifoCount visible at N+1. txStart rises at N+2 when in IDLE with txBusy=0.
- Back-to-back bytes: the next START is entered no earlier than the cycle after the txDone event, and only once txBusy=0.
- enable low at any time:
  - Next cycle: uartEn=0, txStart=0, FSM=IDLE, FIFO flushed (count=0).
  - overflow and errCount are held.
- rx events while uartEn=0 are ignored.
- Reset mid-frame has the same effect as reset above. The attached Uart8 is assumed to be reset or disabled alongside.
- Ordering: bytes are echoed in arrival order; no duplication, no reordering.

Decomposition:
- Shared package uart8_pkg holds:
  - the FSM state enum (IDLE, START, SEND);
  - the byte width constant (8);
  - the count-width function used for fifoCount.
- One sub-module: uart8_sync_fifo. It is a synchronous single-clock FIFO with push, pop, head, count and full/empty outputs, parameterised by DEPTH and width, with synchronous active-low reset. The FSM, edge detect and counters stay in the top module.

Test Plan:
- Loopback at CLOCK_RATE=12000000, 9600 baud. A driver Uart8 sends 0x7A, then 0xB1 -> the responder echoes 0x7A, then 0xB1. The driver receiver sees rxDone with those bytes and rxErr=0. The first txStart rises 2 clk after the responder's rxDone event.
- Burst of 10 bytes 0x00..0x09 with DEPTH=8, sent faster than the echo drains -> overflow=1. Echoed bytes are a strict in-order prefix, with no duplicates. clrOverflow returns overflow to 0.
- Injected framing error (stop bit forced low on byte 0x55), DROP_ON_ERR=1 -> errCount=1 and no echo. The following byte 0x3C is echoed normally.
- rxDone held high for 500 clk cycles with rxByte=0xA5 -> exactly one push, fifoCount=1, one echo.
- Transmitter model holds txBusy at 0 for START_TIMEOUT+1 cycles -> FSM returns to IDLE, the byte is retried, and the second attempt echoes the same byte.
- enable dropped in SEND with 3 bytes queued -> next cycle uartEn=0, txStart=0, fifoCount=0. After re-enable, new byte 0x42 is echoed alone.

Source files
------------

// File: rtl/uart8_pkg.sv
// rtl/uart8_pkg.sv - shared types and constants for the Uart8 echo responder
package uart8_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } resp_state_t;

    function automatic int count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart8_echo_responder_if.sv
// rtl/uart8_echo_responder_if.sv - handshake bundle between the responder and its Uart8
interface uart8_echo_responder_if;
    import uart8_pkg::*;

    logic              uartEn;
    logic              rxDone;
    logic              rxErr;
    logic [BYTE_W-1:0] rxByte;
    logic              txBusy;
    logic              txDone;
    logic              txStart;
    logic [BYTE_W-1:0] txByte;

    modport master (
        output uartEn, txStart, txByte,
        input  rxDone, rxErr, rxByte, txBusy, txDone
    );

    modport slave (
        input  uartEn, txStart, txByte,
        output rxDone, rxErr, rxByte, txBusy, txDone
    );

endinterface

// File: rtl/uart8_sync_fifo.sv
// rtl/uart8_sync_fifo.sv - single-clock FIFO with push-to-head for retried entries
module uart8_sync_fifo
    import uart8_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = count_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             unpop,
    input  logic [WIDTH-1:0] unpop_data,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_prev;

    // Caller guarantees pop and unpop are exclusive and that space exists.
    assign rd_prev = rd_ptr - 1'b1;
    assign head    = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge clk) begin
        if (!rstN || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (unpop) begin
                rd_ptr <= rd_prev;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) + CW'(unpop) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
        if (unpop) begin
            mem[rd_prev] <= unpop_data;
        end
    end

endmodule

// File: rtl/uart8_echo_responder.sv
// rtl/uart8_echo_responder.sv - queues every received Uart8 byte and transmits it back in order
module uart8_echo_responder
    import uart8_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter bit DROP_ON_ERR   = 1'b1,
    parameter int START_TIMEOUT = 4095
) (
    input  logic                      clk,
    input  logic                      rstN,
    input  logic                      enable,
    uart8_echo_responder_if.master    uart,
    output logic [count_w(DEPTH)-1:0] fifoCount,
    output logic                      overflow,
    input  logic                      clrOverflow,
    output logic [7:0]                errCount
);

    localparam int CW = count_w(DEPTH);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    resp_state_t       state;
    resp_state_t       state_next;
    logic              rx_q;
    logic              tx_q;
    logic              rx_evt;
    logic              tx_evt;
    logic              rx_ok;
    logic              want_push;
    logic              push_acc;
    logic              pop;
    logic              unpop;
    logic              unpop_acc;
    logic              drop;
    logic [TW-1:0]     timer;
    logic [BYTE_W-1:0] head;
    logic              full;
    logic              empty;
    logic [CW:0]       used_after;

    assign rx_evt    = uart.rxDone & ~rx_q;
    assign tx_evt    = uart.txDone & ~tx_q;
    assign rx_ok     = rx_evt & uart.uartEn & enable;
    assign want_push = rx_ok & (~uart.rxErr | ~DROP_ON_ERR);

    // A retried byte owns the head slot ahead of any same-cycle arrival.
    assign unpop_acc  = unpop & ~full;
    assign used_after = {1'b0, fifoCount} + (CW+1)'(unpop_acc) - (CW+1)'(pop);
    assign push_acc   = want_push & (used_after < (CW+1)'(DEPTH));
    assign drop       = enable & ((want_push & ~push_acc) | (unpop & ~unpop_acc));

    assign uart.txStart = (state == START);

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unpop      = 1'b0;
        case (state)
            IDLE: begin
                if (uart.uartEn && !empty && !uart.txBusy) begin
                    state_next = START;
                    pop        = 1'b1;
                end
            end
            START: begin
                if (uart.txBusy) begin
                    state_next = SEND;
                end else if (timer == TW'(START_TIMEOUT - 1)) begin
                    state_next = IDLE;
                    unpop      = 1'b1;
                end
            end
            SEND: begin
                if (tx_evt) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state       <= IDLE;
            rx_q        <= 1'b0;
            tx_q        <= 1'b0;
            timer       <= '0;
            uart.uartEn <= 1'b0;
            uart.txByte <= '0;
            overflow    <= 1'b0;
            errCount    <= '0;
        end else begin
            rx_q        <= uart.rxDone;
            tx_q        <= uart.txDone;
            uart.uartEn <= enable;
            if (!enable) begin
                state <= IDLE;
                timer <= '0;
            end else begin
                state <= state_next;
                timer <= (state == START && state_next == START) ? timer + 1'b1 : '0;
                if (pop) begin
                    uart.txByte <= head;
                end
            end
            if (clrOverflow) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
            if (rx_ok && uart.rxErr && errCount != 8'hFF) begin
                errCount <= errCount + 1'b1;
            end
        end
    end

    uart8_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk        (clk),
        .rstN       (rstN),
        .flush      (~enable),
        .push       (push_acc),
        .push_data  (uart.rxByte),
        .pop        (pop),
        .unpop      (unpop_acc),
        .unpop_data (uart.txByte),
        .head       (head),
        .count      (fifoCount),
        .full       (full),
        .empty      (empty)
    );

endmodule

// File: tb/tb_uart8_echo_responder.sv
// tb/tb_uart8_echo_responder.sv - self-checking bench for uart8_echo_responder
module tb_uart8_echo_responder;
    import uart8_pkg::*;

    localparam int DEPTH         = 8;
    localparam int START_TIMEOUT = 4095;
    localparam int CW            = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rstN;
    logic          enable;
    logic          clrOverflow;
    logic [CW-1:0] fifoCount;
    logic          overflow;
    logic [7:0]    errCount;

    uart8_echo_responder_if u ();

    uart8_echo_responder #(
        .DEPTH         (DEPTH),
        .DROP_ON_ERR   (1'b1),
        .START_TIMEOUT (START_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rstN        (rstN),
        .enable      (enable),
        .uart        (u),
        .fifoCount   (fifoCount),
        .overflow    (overflow),
        .clrOverflow (clrOverflow),
        .errCount    (errCount)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural reference: accepted bytes in arrival order, and error tally.
    logic [7:0] exp_q[$];
    logic [7:0] echoed[$];
    int         err_model = 0;
    bit         model_en  = 0;

    bit tx_auto  = 1;
    bit tx_idle  = 1;
    int busy_min = 3;
    int busy_max = 10;

    typedef struct {
        logic [7:0] data;
        bit         err;
        int         hold;
        int         exp_echo;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit err, input int hold);
        @(negedge clk);
        u.rxByte = b;
        u.rxErr  = err;
        u.rxDone = 1'b1;
        if (model_en && err && err_model < 255) err_model++;
        repeat (hold) @(negedge clk);
        u.rxDone = 1'b0;
        u.rxErr  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_echoes(input string name, input int n, input int limit);
        int c = 0;
        while (echoed.size() < n && c < limit) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(c < limit), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (!(tx_idle && fifoCount == 0 && !u.txStart && !u.txBusy && !u.txDone) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        check(name, 32'(c < 2000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Transmitter model: acknowledges txStart, stays busy, then pulses txDone.
    initial begin
        logic [7:0] b;
        u.txBusy = 1'b0;
        u.txDone = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_auto && u.txStart) begin
                tx_idle = 0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
                b = u.txByte;
                u.txBusy = 1'b1;
                repeat ($urandom_range(busy_min, busy_max)) @(negedge clk);
                if (enable) check("tx_byte_stable", 32'(u.txByte), 32'(b));
                u.txBusy = 1'b0;
                u.txDone = 1'b1;
                echoed.push_back(b);
                repeat ($urandom_range(1, 5)) @(negedge clk);
                u.txDone = 1'b0;
                tx_idle  = 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [7:0] b;
        bit e;

        vecs[0] = '{8'h7A, 1'b0, 1,   1};
        vecs[1] = '{8'hB1, 1'b0, 3,   1};
        vecs[2] = '{8'h55, 1'b1, 2,   0};
        vecs[3] = '{8'h3C, 1'b0, 1,   1};
        vecs[4] = '{8'hA5, 1'b0, 500, 1};
        vecs[5] = '{8'h00, 1'b0, 1,   1};

        rstN = 1'b0; enable = 1'b1; clrOverflow = 1'b0;
        u.rxDone = 1'b0; u.rxErr = 1'b0; u.rxByte = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_uartEn",    32'(u.uartEn),  32'd0);
        check("rst_txStart",   32'(u.txStart), 32'd0);
        check("rst_txByte",    32'(u.txByte),  32'd0);
        check("rst_fifoCount", 32'(fifoCount), 32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_errCount",  32'(errCount),  32'd0);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        check("uartEn_follows", 32'(u.uartEn), 32'd1);
        model_en = 1;

        foreach (vecs[i]) begin
            echoed.delete();
            send_byte(vecs[i].data, vecs[i].err, vecs[i].hold);
            if (vecs[i].exp_echo > 0) wait_echoes($sformatf("vec%0d_echo_wait", i), 1, 400);
            else repeat (60) @(negedge clk);
            wait_idle($sformatf("vec%0d_idle", i));
            repeat (20) @(negedge clk);
            check($sformatf("vec%0d_echo_count", i), 32'(echoed.size()), 32'(vecs[i].exp_echo));
            if (vecs[i].exp_echo > 0 && echoed.size() > 0)
                check($sformatf("vec%0d_echo_byte", i), 32'(echoed[0]), 32'(vecs[i].data));
            check($sformatf("vec%0d_errCount", i), 32'(errCount), 32'(err_model));
        end

        // Latency and start timeout with a transmitter that never answers.
        tx_auto = 0;
        echoed.delete();
        @(negedge clk);
        u.rxByte = 8'h66; u.rxDone = 1'b1;
        @(negedge clk);
        u.rxDone = 1'b0;
        check("lat_count_n1",   32'(fifoCount), 32'd1);
        check("lat_start_n1",   32'(u.txStart), 32'd0);
        @(negedge clk);
        check("lat_start_n2",   32'(u.txStart), 32'd1);
        check("lat_popped_n2",  32'(fifoCount), 32'd0);
        check("lat_txByte",     32'(u.txByte),  32'h66);
        cnt = 1;
        while (cnt < START_TIMEOUT + 10) begin
            @(negedge clk);
            if (!u.txStart) break;
            cnt++;
        end
        check("timeout_len",    32'(cnt),       32'(START_TIMEOUT));
        check("retry_requeued", 32'(fifoCount), 32'd1);
        @(negedge clk);
        check("retry_restart",  32'(u.txStart), 32'd1);
        tx_auto = 1;
        wait_echoes("retry_echo_wait", 1, 400);
        wait_idle("retry_idle");
        check("retry_echo_count", 32'(echoed.size()), 32'd1);
        if (echoed.size() > 0) check("retry_echo_byte", 32'(echoed[0]), 32'h66);

        // Burst beyond capacity against a slow transmitter.
        busy_min = 300; busy_max = 300;
        echoed.delete();
        for (int i = 0; i < 10; i++) begin
            send_byte(8'(i), 1'b0, 1);
            repeat (2) @(negedge clk);
        end
        check("burst_overflow", 32'(overflow),  32'd1);
        check("burst_full",     32'(fifoCount), 32'(DEPTH));
        wait_echoes("burst_echo_wait", DEPTH + 1, 6000);
        wait_idle("burst_idle");
        check("burst_echo_count", 32'(echoed.size()), 32'(DEPTH + 1));
        for (int i = 0; i < echoed.size() && i <= DEPTH; i++)
            check($sformatf("burst_echo%0d", i), 32'(echoed[i]), 32'(i));
        check("overflow_sticky", 32'(overflow), 32'd1);
        clrOverflow = 1'b1;
        @(negedge clk);
        clrOverflow = 1'b0;
        check("overflow_cleared", 32'(overflow), 32'd0);

        // Disable while sending with three bytes queued.
        echoed.delete();
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hC0 + 8'(i), 1'b0, 1);
            repeat (2) @(negedge clk);
        end
        cnt = 0;
        while (!(u.txBusy && fifoCount == 3) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("dis_setup", 32'(cnt < 100), 32'd1);
        enable = 1'b0; model_en = 0;
        @(negedge clk);
        check("dis_uartEn",    32'(u.uartEn),  32'd0);
        check("dis_txStart",   32'(u.txStart), 32'd0);
        check("dis_fifoCount", 32'(fifoCount), 32'd0);
        check("dis_overflow",  32'(overflow),  32'd0);
        check("dis_errCount",  32'(errCount),  32'(err_model));
        send_byte(8'h99, 1'b1, 2);
        send_byte(8'h98, 1'b0, 2);
        check("dis_rx_ignored",  32'(fifoCount), 32'd0);
        check("dis_err_ignored", 32'(errCount),  32'(err_model));
        cnt = 0;
        while (!(tx_idle && !u.txBusy) && cnt < 600) begin
            @(negedge clk);
            cnt++;
        end
        check("dis_tx_drain", 32'(cnt < 600), 32'd1);
        busy_min = 3; busy_max = 10;
        echoed.delete();
        enable = 1'b1;
        repeat (2) @(negedge clk);
        model_en = 1;
        send_byte(8'h42, 1'b0, 1);
        wait_echoes("reen_echo_wait", 1, 400);
        wait_idle("reen_idle");
        check("reen_echo_count", 32'(echoed.size()), 32'd1);
        if (echoed.size() > 0) check("reen_echo_byte", 32'(echoed[0]), 32'h42);

        // Randomized traffic kept below capacity, compared with the reference queue.
        echoed.delete();
        exp_q.delete();
        for (int n = 0; n < 40; n++) begin
            cnt = 0;
            while ((exp_q.size() - echoed.size()) >= DEPTH - 1 && cnt < 2000) begin
                @(negedge clk);
                cnt++;
            end
            if (cnt >= 2000) check("rand_backpressure", 32'd0, 32'd1);
            b = 8'($urandom);
            e = ($urandom_range(0, 5) == 0);
            if (!e) exp_q.push_back(b);
            send_byte(b, e, $urandom_range(1, 4));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_echoes("rand_echo_wait", exp_q.size(), 5000);
        wait_idle("rand_idle");
        check("rand_echo_count", 32'(echoed.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < echoed.size(); i++)
            check($sformatf("rand_echo%0d", i), 32'(echoed[i]), 32'(exp_q[i]));
        check("rand_errCount", 32'(errCount), 32'(err_model));
        check("rand_no_overflow", 32'(overflow), 32'd0);

        // Error counter saturation.
        echoed.delete();
        for (int i = 0; i < 256; i++) send_byte(8'hE0, 1'b1, 1);
        check("sat_errCount_model", 32'(errCount), 32'(err_model));
        check("sat_errCount_max",   32'(errCount), 32'd255);
        check("sat_no_push",        32'(fifoCount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
